// File: rtl/sdpram_arb_pkg.sv
// Shared constants and types for the simple dual-port RAM arbiter.
//   NUM_REQ_DEF / ADDR_WIDTH_DEF / DATA_WIDTH_DEF / RD_LAT_DEF : default sizes
//   TAG_IDX_W : width of the requester index carried with each read (max 8 requesters)
//   rd_tag_t  : read-return tag, valid bit plus requester index
package sdpram_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int RD_LAT_DEF     = 2;
    localparam int TAG_IDX_W      = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/sdpram_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector, one bit per requester
//   ptr     : requester with highest priority this cycle
//   gnt     : one-hot grant (all zero when nothing is requested)
//   ptr_nxt : pointer to load if the grant is taken (winner + 1, wrapping);
//             equals ptr when nothing is granted
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] ptr_nxt
);

    logic found;

    // Two scans give the wrapped search order: first ptr..N-1, then 0..ptr-1.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i]  = 1'b1;
                ptr_nxt = (i == N - 1) ? '0 : PTR_W'(i + 1);
                found   = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                gnt[i]  = 1'b1;
                ptr_nxt = (i == N - 1) ? '0 : PTR_W'(i + 1);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdpram_arbiter.sv
// Round-robin arbiter sharing one simple dual-port RAM among NUM_REQ clients.
// Write port A and read port B are arbitrated independently every cycle;
// read data returns RD_LAT+1 cycles after the grant, tagged by rd_dval.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data -> wr_gnt   write requests (packed, client i at slice i)
//   rd_req/rd_addr     -> rd_gnt       read requests
//   rd_data, rd_dval                   shared return data, one-hot owner valid
//   ram_wena/ram_addra/ram_dina        RAM write port (registered)
//   ram_addrb, ram_doutb               RAM read port
//
// Build option: SDPRAM_ARB_RAW_STALL_EN -- when defined, a read whose address
// matches the same-cycle write winner is held off one cycle so it returns the
// new data; otherwise a same-address collision returns the old data.
module sdpram_arbiter
    import sdpram_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_LAT     = RD_LAT_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               wr_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data,
    output logic [NUM_REQ-1:0]               wr_gnt,
    input  logic [NUM_REQ-1:0]               rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    rd_addr,
    output logic [NUM_REQ-1:0]               rd_gnt,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic [NUM_REQ-1:0]               rd_dval,
    output logic                             ram_wena,
    output logic [ADDR_WIDTH-1:0]            ram_addra,
    output logic [DATA_WIDTH-1:0]            ram_dina,
    output logic [ADDR_WIDTH-1:0]            ram_addrb,
    input  logic [DATA_WIDTH-1:0]            ram_doutb
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]      rd_ptr, rd_ptr_nxt;
    logic [NUM_REQ-1:0]    wr_gnt_arb, rd_gnt_arb;
    logic [ADDR_WIDTH-1:0] wr_addr_sel, rd_addr_sel;
    logic [DATA_WIDTH-1:0] wr_data_sel;
    logic [TAG_IDX_W-1:0]  rd_idx;
    logic                  raw_stall;
    logic                  wr_fire, rd_fire;
    rd_tag_t               tag_p [RD_LAT+1];

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .req     (wr_req),
        .ptr     (wr_ptr),
        .gnt     (wr_gnt_arb),
        .ptr_nxt (wr_ptr_nxt)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .req     (rd_req),
        .ptr     (rd_ptr),
        .gnt     (rd_gnt_arb),
        .ptr_nxt (rd_ptr_nxt)
    );

    // Winner muxes: grants are one-hot, so at most one slice is selected.
    always_comb begin
        wr_addr_sel = '0;
        wr_data_sel = '0;
        rd_addr_sel = '0;
        rd_idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt_arb[i]) begin
                wr_addr_sel = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data_sel = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_gnt_arb[i]) begin
                rd_addr_sel = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                rd_idx      = TAG_IDX_W'(i);
            end
        end
    end

`ifdef SDPRAM_ARB_RAW_STALL_EN
    // Holding the read one cycle lets the write commit first, so the read
    // sees the new word; the read pointer stays put because rd_fire is low.
    assign raw_stall = (|wr_gnt_arb) && (|rd_gnt_arb) && (wr_addr_sel == rd_addr_sel);
`else
    assign raw_stall = 1'b0;
`endif

    assign wr_gnt  = rst ? '0 : wr_gnt_arb;
    assign rd_gnt  = (rst || raw_stall) ? '0 : rd_gnt_arb;
    assign wr_fire = |wr_gnt;
    assign rd_fire = |rd_gnt;

    // Stage p0: grant -> RAM port registers and pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_wena  <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
            ram_addrb <= '0;
        end else begin
            ram_wena <= wr_fire;
            if (wr_fire) begin
                wr_ptr    <= wr_ptr_nxt;
                ram_addra <= wr_addr_sel;
                ram_dina  <= wr_data_sel;
            end
            if (rd_fire) begin
                rd_ptr    <= rd_ptr_nxt;
                ram_addrb <= rd_addr_sel;
            end
        end
    end

    // Stages p0..pRD_LAT: read tag travels alongside the RAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_p[k] <= '0;
            end
        end else begin
            tag_p[0].valid <= rd_fire;
            tag_p[0].idx   <= rd_idx;
            for (int k = 1; k <= RD_LAT; k++) begin
                tag_p[k] <= tag_p[k-1];
            end
        end
    end

    // Return stage: RAM data is forwarded unregistered, qualified by the tag
    always_comb begin
        rd_dval = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst && tag_p[RD_LAT].valid && (tag_p[RD_LAT].idx == TAG_IDX_W'(i))) begin
                rd_dval[i] = 1'b1;
            end
        end
    end

    assign rd_data = ram_doutb;

endmodule

// File: tb/tb_sdpram_arbiter.sv
// Bench for sdpram_arbiter: directed scenarios plus randomized client traffic,
// compared every cycle against a behavioural model (round-robin search,
// shadow memory, queue of expected read returns). Contains its own RAM model.
// Build option SDPRAM_ARB_RAW_STALL_EN switches the collision expectations.
module tb_sdpram_arbiter;

    localparam int N     = 4;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int RL    = 2;
    localparam int DEPTH = 1 << AW;

    logic              clk;
    logic              rst;
    logic [N-1:0]      wr_req, rd_req;
    logic [N*AW-1:0]   wr_addr, rd_addr;
    logic [N*DW-1:0]   wr_data;
    logic [N-1:0]      wr_gnt, rd_gnt, rd_dval;
    logic [DW-1:0]     rd_data;
    logic              ram_wena;
    logic [AW-1:0]     ram_addra, ram_addrb;
    logic [DW-1:0]     ram_dina, ram_doutb;

    sdpram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_dval(rd_dval),
        .ram_wena(ram_wena), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        logic [31:0] t;
        t = 32'(a) * 32'h9E3779B1;
        return t ^ 32'h0BADF00D;
    endfunction

    // RAM model: write commits at the edge, read samples old contents, RL cycles latency
    logic          fill;
    logic [DW-1:0] mem   [DEPTH];
    logic [DW-1:0] rpipe [RL];

    always @(posedge clk) begin
        if (fill) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= init_val(a);
        end else if (ram_wena) begin
            mem[ram_addra] <= ram_dina;
        end
        rpipe[0] <= mem[ram_addrb];
        for (int k = 1; k < RL; k++) rpipe[k] <= rpipe[k-1];
    end
    assign ram_doutb = rpipe[RL-1];

    // Reference state
    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    rd_exp_t       rq [$];
    int            wptr, rptr, cyc;
    logic          exp_known, exp_wena;
    logic [AW-1:0] exp_addra, exp_addrb;
    logic [DW-1:0] exp_dina;

    logic          w_pend [N];
    logic [AW-1:0] w_a    [N];
    logic [DW-1:0] w_d    [N];
    logic          r_pend [N];
    logic [AW-1:0] r_a    [N];
    logic          rst_next;

    logic [N-1:0]  last_wg, last_rg, last_dval;
    logic [DW-1:0] last_data;

    int n_chk, n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = req >> ((ptr + k) % N);
            if (t[0]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic any_pend();
        for (int i = 0; i < N; i++) if (w_pend[i] || r_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive after the edge, check and advance the model at negedge
    task automatic step();
        int           wi, ri;
        logic [N-1:0] eg, erg, ed;
        @(posedge clk);
        #1;
        rst = rst_next;
        for (int i = 0; i < N; i++) begin
            wr_req[i]            = w_pend[i];
            wr_addr[i*AW +: AW]  = w_a[i];
            wr_data[i*DW +: DW]  = w_d[i];
            rd_req[i]            = r_pend[i];
            rd_addr[i*AW +: AW]  = r_a[i];
        end
        @(negedge clk);
        cyc++;
        if (exp_known) begin
            chk("ram_wena", 64'(ram_wena), 64'(exp_wena));
            chk("ram_addra", 64'(ram_addra), 64'(exp_addra));
            chk("ram_dina", 64'(ram_dina), 64'(exp_dina));
            chk("ram_addrb", 64'(ram_addrb), 64'(exp_addrb));
        end
        if (rst) rq.delete();
        ed = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ed = N'(1) << rq[0].idx;
            chk("rd_data", 64'(rd_data), 64'(rq[0].data));
            void'(rq.pop_front());
        end
        chk("rd_dval", 64'(rd_dval), 64'(ed));
        last_dval = rd_dval;
        last_data = rd_data;
        last_wg   = wr_gnt;
        last_rg   = rd_gnt;
        if (rst) begin
            chk("wr_gnt_rst", 64'(wr_gnt), 64'(0));
            chk("rd_gnt_rst", 64'(rd_gnt), 64'(0));
            wptr = 0; rptr = 0;
            exp_wena = 1'b0; exp_addra = '0; exp_dina = '0; exp_addrb = '0;
            exp_known = 1'b1;
        end else begin
            wi = rr_pick(wr_req, wptr);
            ri = rr_pick(rd_req, rptr);
`ifdef SDPRAM_ARB_RAW_STALL_EN
            if (wi >= 0 && ri >= 0 && r_a[ri] == w_a[wi]) ri = -1;
`endif
            eg  = (wi >= 0) ? (N'(1) << wi) : '0;
            erg = (ri >= 0) ? (N'(1) << ri) : '0;
            chk("wr_gnt", 64'(wr_gnt), 64'(eg));
            chk("rd_gnt", 64'(rd_gnt), 64'(erg));
            // Read-first: the read sees memory before this cycle's write
            if (ri >= 0) begin
                rq.push_back('{due: cyc + 1 + RL, idx: ri, data: ref_mem[r_a[ri]]});
                rptr      = (ri + 1) % N;
                exp_addrb = r_a[ri];
                r_pend[ri] = 1'b0;
            end
            if (wi >= 0) begin
                ref_mem[w_a[wi]] = w_d[wi];
                exp_wena  = 1'b1;
                exp_addra = w_a[wi];
                exp_dina  = w_d[wi];
                wptr      = (wi + 1) % N;
                w_pend[wi] = 1'b0;
            end else begin
                exp_wena = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (any_pend() && guard < 64) begin
            step();
            guard++;
        end
        chk("drain_done", 64'(any_pend()), 64'(0));
    endtask

    initial begin
        logic seen;
        logic [DW-1:0] got;
        n_chk = 0; n_pass = 0; cyc = 0;
        exp_known = 1'b0; exp_wena = 1'b0;
        exp_addra = '0; exp_addrb = '0; exp_dina = '0;
        wptr = 0; rptr = 0;
        rst = 1'b1; rst_next = 1'b1; fill = 1'b1;
        wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        for (int i = 0; i < N; i++) begin
            w_pend[i] = 1'b0; r_pend[i] = 1'b0; w_a[i] = '0; w_d[i] = '0; r_a[i] = '0;
        end
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_val(a);

        // Reset then idle
        step();
        fill = 1'b0;
        idle(2);
        chk("rst_wr_gnt", 64'(wr_gnt), 64'(0));
        chk("rst_rd_gnt", 64'(rd_gnt), 64'(0));
        chk("rst_ram_wena", 64'(ram_wena), 64'(0));
        chk("rst_rd_dval", 64'(rd_dval), 64'(0));
        chk("rst_ram_addrb", 64'(ram_addrb), 64'(0));
        rst_next = 1'b0;

        // Single write then read by requester 1
        w_pend[1] = 1'b1; w_a[1] = 10'h005; w_d[1] = 32'hDEADBEEF;
        step();
        chk("single_wr_gnt", 64'(last_wg), 64'(4'b0010));
        step();
        chk("single_ram_wena", 64'(ram_wena), 64'(1));
        chk("single_ram_addra", 64'(ram_addra), 64'(10'h005));
        r_pend[1] = 1'b1; r_a[1] = 10'h005;
        step();
        chk("single_rd_gnt", 64'(last_rg), 64'(4'b0010));
        idle(RL + 1);
        chk("single_rd_dval", 64'(last_dval), 64'(4'b0010));
        chk("single_rd_data", 64'(last_data), 64'(32'hDEADBEEF));

        // Fairness from a fresh pointer: all four writers held
        rst_next = 1'b1; step(); rst_next = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_pend[i]) begin
                    w_pend[i] = 1'b1; w_a[i] = AW'($urandom_range(256, 511)); w_d[i] = $urandom;
                end
            end
            step();
            chk("fair_wr_gnt", 64'(last_wg), 64'(N'(1) << (k % N)));
        end
        drain();

        // Read pipelining on preloaded words
        for (int i = 0; i < N; i++) begin
            w_pend[i] = 1'b1; w_a[i] = AW'(i); w_d[i] = 32'hA0 + 32'(i);
        end
        drain();
        idle(2);
        for (int i = 0; i < N; i++) begin
            r_pend[i] = 1'b1; r_a[i] = AW'(i);
        end
        step();
        chk("pipe_rd_gnt0", 64'(last_rg), 64'(4'b0001));
        idle(RL);
        for (int k = 0; k < N; k++) begin
            step();
            chk("pipe_rd_dval", 64'(last_dval), 64'(N'(1) << k));
            chk("pipe_rd_data", 64'(last_data), 64'(32'hA0 + 32'(k)));
        end

        // Same-address write and read in one cycle
        w_pend[2] = 1'b1; w_a[2] = 10'h010; w_d[2] = 32'h11;
        drain();
        idle(2);
        w_pend[0] = 1'b1; w_a[0] = 10'h010; w_d[0] = 32'h55;
        r_pend[1] = 1'b1; r_a[1] = 10'h010;
        step();
        chk("coll_wr_gnt", 64'(last_wg), 64'(4'b0001));
`ifdef SDPRAM_ARB_RAW_STALL_EN
        chk("coll_rd_gnt", 64'(last_rg), 64'(4'b0000));
`else
        chk("coll_rd_gnt", 64'(last_rg), 64'(4'b0010));
`endif
        seen = 1'b0; got = '0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (last_dval[1]) begin seen = 1'b1; got = last_data; end
        end
        chk("coll_seen", 64'(seen), 64'(1));
`ifdef SDPRAM_ARB_RAW_STALL_EN
        chk("coll_rd_data", 64'(got), 64'(32'h55));
`else
        chk("coll_rd_data", 64'(got), 64'(32'h11));
`endif

        // Reset with two reads in flight
        idle(2);
        r_pend[0] = 1'b1; r_a[0] = 10'h020;
        r_pend[1] = 1'b1; r_a[1] = 10'h021;
        step();
        step();
        rst_next = 1'b1; step(); rst_next = 1'b0;
        for (int k = 0; k < RL + 3; k++) begin
            step();
            chk("rst_drop_dval", 64'(last_dval), 64'(0));
        end
        for (int i = 0; i < N; i++) begin
            w_pend[i] = 1'b1; w_a[i] = AW'($urandom_range(0, 15)); w_d[i] = $urandom;
            r_pend[i] = 1'b1; r_a[i] = AW'($urandom_range(0, 15));
        end
        step();
        chk("rst_ptr_wr", 64'(last_wg), 64'(4'b0001));
        chk("rst_ptr_rd", 64'(last_rg), 64'(4'b0001));
        drain();

        // Randomized traffic with narrow addresses to provoke collisions
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_pend[i] && $urandom_range(0, 1) == 1) begin
                    w_pend[i] = 1'b1;
                    w_a[i] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                    w_d[i] = $urandom;
                end
                if (!r_pend[i] && $urandom_range(0, 1) == 1) begin
                    r_pend[i] = 1'b1;
                    r_a[i] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                end
            end
            rst_next = ($urandom_range(0, 99) == 0);
            step();
        end
        rst_next = 1'b0;
        drain();
        idle(RL + 3);
        chk("returns_flushed", 64'(rq.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdpram_arbiter.md
Name: sdpram_arbiter

Overview:
- Round-robin arbiter that shares one simple dual-port RAM among NUM_REQ requesters.
- Write port A and read port B are arbitrated independently every cycle.
- Returning read data is tagged to the requester that issued the read.
- Sits between client blocks and simple_dual_port_ram; it is the only driver of the RAM's port signals.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 10, RAM address width; MEM_DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width.
- RD_LAT, 2, cycles from ram_addrb valid to ram_doutb valid (1..4).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  NUM_REQ  per-requester write request.
- wr_addr  in  NUM_REQ*ADDR_WIDTH  packed write addresses, requester i at slice i.
- wr_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- wr_gnt  out  NUM_REQ  one-hot write grant.
- rd_req  in  NUM_REQ  per-requester read request.
- rd_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses.
- rd_gnt  out  NUM_REQ  one-hot read grant.
- rd_data  out  DATA_WIDTH  returned read data, shared by all requesters.
- rd_dval  out  NUM_REQ  one-hot valid, qualifies rd_data for requester i.
- ram_wena  out  1  RAM write enable.
- ram_addra  out  ADDR_WIDTH  RAM write address.
- ram_dina  out  DATA_WIDTH  RAM write data.
- ram_addrb  out  ADDR_WIDTH  RAM read address.
- ram_doutb  in  DATA_WIDTH  RAM read data.

Behaviour:
- Handshake
  - Requester raises req with addr/data and holds all three stable until it sees gnt high.
  - gnt is combinational from req and the priority pointer, at most one bit per side per cycle.
  - Transfer completes at the edge where req and gnt are both high.
  - Requester may drop req or present a new request in the next cycle.
- Round-robin
  - Each side has a pointer, ptr, of width $clog2(NUM_REQ).
  - Search starts at ptr and wraps NUM_REQ-1 -> 0.
  - On a grant to i, ptr <= (i+1) mod NUM_REQ.
  - No grant leaves ptr unchanged.
  - Reset: ptr = 0, so requester 0 has highest priority.
- Write path
  - A write granted in cycle T registers ram_wena=1, ram_addra, ram_dina, visible in T+1.
  - The RAM commits the write at the end of T+1.
  - With no grant, ram_wena=0 in the next cycle; ram_addra and ram_dina hold their last values.
- Read path
  - A read granted in cycle T registers ram_addrb, visible in T+1. ram_addrb holds when idle.
  - A tag pipeline of depth RD_LAT+1 carries (valid, requester index).
  - rd_dval[i]=1 exactly in cycle T+1+RD_LAT.
  - rd_data = ram_doutb, passed through combinationally; it is don't-care when rd_dval is 0.
  - Back-to-back reads are accepted every cycle, giving one rd_dval per cycle with no bubbles.
- Collision
  - A same-address write and read granted in the same cycle returns the OLD data (read-first), unless the optional feature below is compiled in.
- Reset values
  - wr_gnt, rd_gnt combinationally 0 while rst=1.
  - ram_wena=0, ram_addra=0, ram_dina=0, ram_addrb=0.
  - rd_dval=0 and tag pipeline cleared.
  - Reset mid-operation drops all in-flight reads: no rd_dval is issued for them.
- Boundaries
  - All requesters active: each side grants each requester once per NUM_REQ cycles.
  - A single requester is granted every cycle.
  - Addresses wrap naturally within ADDR_WIDTH; no range check.

Optional Feature:
- Macro: SDPRAM_ARB_RAW_STALL_EN.
- Defined: if the read winner's address equals the write winner's address in the same cycle:
  - rd_gnt is suppressed for that cycle and the read ptr does not advance.
  - The write proceeds.
  - The read is granted the next cycle, provided it still wins arbitration, and returns the NEW data.
- Undefined: no comparison logic; read-first old data is returned.

Decomposition:
- Package sdpram_arb_pkg holds:
  - the default width constants;
  - typedef rd_tag_t, a struct of valid bit plus requester index.
- One sub-module, rr_arbiter: parameter N; inputs req and ptr; outputs one-hot gnt and the next ptr.
  - Instantiated twice, once for writes and once for reads.

Test Plan:
- Reset then idle: rst high 3 cycles, all req=0 -> all gnt=0, ram_wena=0, rd_dval=0, ram_addrb=0.
- Single write/read
  - Req1 writes addr 0x005 data 0xDEADBEEF at T -> wr_gnt=0010 at T; ram_wena=1, addra=0x005 at T+1.
  - Req1 reads 0x005 later at T' -> rd_dval=0010 at T'+3 (RD_LAT=2) with rd_data=0xDEADBEEF.
- Fairness: all 4 wr_req held 8 cycles -> wr_gnt sequence 0001,0010,0100,1000,0001,... with each requester granted twice.
- Read pipelining: rd_req from req0..3 back-to-back on addrs 0..3, preloaded 0xA0..0xA3 -> rd_dval one-hot on 4 consecutive cycles starting T+3, data matches.
- Collision: write 0x010=0x55 while reading 0x010, which holds 0x11.
  - Without the macro: read returns 0x11.
  - With SDPRAM_ARB_RAW_STALL_EN: rd_gnt is delayed one cycle and the read returns 0x55.
- Mid-operation reset: two reads in flight, rst asserted at T+1 -> no rd_dval in the following cycles; ptr back to 0.
